// File: rtl/branch_predict_unit_pkg.sv
// Shared definitions for the branch predict unit.
// Contents: funct3 branch encodings, 2-bit counter state constants and the
// saturating counter update helper.
package branch_predict_unit_pkg;

  // Conditional branch funct3 encodings
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_RSV2 = 3'b010;
  localparam logic [2:0] F3_RSV3 = 3'b011;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // 2-bit predictor counter states
  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  // Saturating step toward taken / not-taken
  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    res = cnt;
    if (taken) begin
      if (cnt != CNT_ST) res = cnt + 2'd1;
    end else begin
      if (cnt != CNT_SNT) res = cnt - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/branch_predict_unit_cond_eval.sv
// Branch outcome decode: turns funct3 plus ALU flags into taken / not taken.
// Ports: funct3 (branch type), zero (ALU zero), lt (ALU less-than),
//        taken (combinational outcome).
module branch_cond_eval
  import branch_predict_unit_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       lt,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:           taken = zero;
      F3_BNE:           taken = !zero;
      F3_BLT, F3_BLTU:  taken = lt;
      F3_BGE, F3_BGEU:  taken = !lt;
      // reserved encodings resolve as not taken
      default:          taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor with mispredict redirect and performance counters.
// Ports: clk/reset (async active-high); f_pc -> f_pred_taken (combinational
//        lookup); ex_* resolve the EX-stage branch; redirect/redirect_pc are
//        the registered correction; branch_cnt/mispred_cnt are saturating
//        event counters.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  f_pc,
  output logic             f_pred_taken,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic [2:0]       ex_funct3,
  input  logic             ex_zero,
  input  logic             ex_lt,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             ex_pred_taken,
  output logic             redirect,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

  logic [1:0]       bht [BHT_ENTRIES];
  logic [IDX_W-1:0] f_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             taken;
  logic             resolve;
  logic             mispred;
  logic [XLEN-1:0]  correct_pc;

  // Only the word-index bits of the fetch PC address the table
  logic unused_fpc_bits;
  assign unused_fpc_bits = ^{f_pc[XLEN-1:IDX_W+2], f_pc[1:0]};

  assign f_idx  = f_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];

  // Lookup reads the registered table, so a same-cycle update is not seen
  assign f_pred_taken = bht[f_idx][1];

  branch_cond_eval u_cond (
    .funct3 (ex_funct3),
    .zero   (ex_zero),
    .lt     (ex_lt),
    .taken  (taken)
  );

  // The instruction in EX during a redirect cycle is wrong-path and ignored
  assign resolve    = ex_valid && ex_is_branch && !redirect;
  assign mispred    = resolve && (taken != ex_pred_taken);
  assign correct_pc = taken ? ex_target : (ex_pc + XLEN'(4));

  // Predictor table
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) bht[i] <= CNT_WNT;
    end else if (resolve) begin
      bht[ex_idx] <= sat_update(bht[ex_idx], taken);
    end
  end

  // Redirect register; redirect_pc holds between mispredicts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redirect    <= 1'b0;
      redirect_pc <= '0;
    end else begin
      redirect <= mispred;
      if (mispred) redirect_pc <= correct_pc;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (resolve && (branch_cnt != '1))  branch_cnt  <= branch_cnt + CNT_W'(1);
      if (mispred && (mispred_cnt != '1)) mispred_cnt <= mispred_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: a driver issues one stimulus per
// cycle and pushes the reference model's expected response; a monitor pops
// and compares against the DUT outputs.
module tb_branch_predict_unit;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned ENTRIES = 64;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [XLEN-1:0]  f_pc = '0;
  logic             f_pred_taken;
  logic             ex_valid = 1'b0;
  logic             ex_is_branch = 1'b0;
  logic [2:0]       ex_funct3 = '0;
  logic             ex_zero = 1'b0;
  logic             ex_lt = 1'b0;
  logic [XLEN-1:0]  ex_pc = '0;
  logic [XLEN-1:0]  ex_target = '0;
  logic             ex_pred_taken = 1'b0;
  logic             redirect;
  logic [XLEN-1:0]  redirect_pc;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  branch_predict_unit #(.XLEN(XLEN), .BHT_ENTRIES(ENTRIES), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .f_pc(f_pc), .f_pred_taken(f_pred_taken),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_funct3(ex_funct3),
    .ex_zero(ex_zero), .ex_lt(ex_lt), .ex_pc(ex_pc), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .redirect(redirect), .redirect_pc(redirect_pc),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        pred;
    bit        red;
    bit [31:0] rpc;
    int        bcnt;
    int        mcnt;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state
  int        m_tbl [ENTRIES];
  bit        m_red;
  bit [31:0] m_rpc;
  int        m_bcnt, m_mcnt;

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int slot(input bit [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic bit outcome(input bit [2:0] f3, input bit z, input bit lt);
    case (f3)
      3'd0:       return z;
      3'd1:       return !z;
      3'd4, 3'd6: return lt;
      3'd5, 3'd7: return !lt;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) m_tbl[i] = 1;
    m_red = 0; m_rpc = 0; m_bcnt = 0; m_mcnt = 0;
  endfunction

  // One cycle of stimulus plus the expected response after the next edge
  task automatic drive(input bit v, input bit br, input bit [2:0] f3, input bit z,
                       input bit lt, input bit [31:0] pc, input bit [31:0] tgt,
                       input bit pred, input bit [31:0] fpc);
    exp_t e;
    bit   tk, miss;
    @(negedge clk);
    ex_valid = v; ex_is_branch = br; ex_funct3 = f3; ex_zero = z; ex_lt = lt;
    ex_pc = pc; ex_target = tgt; ex_pred_taken = pred; f_pc = fpc;
    e.pred = (m_tbl[slot(fpc)] >= 2);
    miss = 0;
    if (v && br && !m_red) begin
      tk = outcome(f3, z, lt);
      if (tk) m_tbl[slot(pc)] = (m_tbl[slot(pc)] == 3) ? 3 : m_tbl[slot(pc)] + 1;
      else    m_tbl[slot(pc)] = (m_tbl[slot(pc)] == 0) ? 0 : m_tbl[slot(pc)] - 1;
      if (m_bcnt < CNT_MAX) m_bcnt++;
      if (tk != pred) begin
        miss = 1;
        if (m_mcnt < CNT_MAX) m_mcnt++;
        m_rpc = tk ? tgt : pc + 32'd4;
      end
    end
    m_red = miss;
    e.red = m_red; e.rpc = m_rpc; e.bcnt = m_bcnt; e.mcnt = m_mcnt;
    exp_q.push_back(e);
  endtask

  task automatic idle(input bit [31:0] fpc);
    drive(0, 0, 3'd0, 0, 0, 32'h0, 32'h0, 0, fpc);
  endtask

  // Asynchronous reset pulse mid-cycle; outputs must clear without a clock edge
  task automatic reset_mid();
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_redirect", redirect, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_branch_cnt", branch_cnt, 0);
    chk("rst_mispred_cnt", mispred_cnt, 0);
    chk("rst_pred", f_pred_taken, 0);
    #1 reset = 1'b0;
    model_reset();
  endtask

  // Monitor: pred sampled late in the low phase, registers just after the edge
  initial begin
    bit   p;
    exp_t e;
    forever begin
      @(negedge clk);
      #4 p = f_pred_taken;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("f_pred_taken", p, e.pred);
        chk("redirect", redirect, e.red);
        chk("redirect_pc", redirect_pc, e.rpc);
        chk("branch_cnt", branch_cnt, e.bcnt);
        chk("mispred_cnt", mispred_cnt, e.mcnt);
      end
    end
  end

  bit [31:0] pcs [5] = '{32'h100, 32'h104, 32'h1FC, 32'h300, 32'h4000_0108};

  initial begin
    bit [31:0] pc, fpc;
    bit [2:0]  f3;
    bit        z, lt, pr;
    model_reset();
    #12 reset = 1'b0;

    // Fresh state: not-taken everywhere, zero counts
    for (int i = 0; i < 3; i++) idle($urandom);

    // Mispredicted taken beq, then lookup sees the strengthened counter
    drive(1, 1, 3'd0, 1, 0, 32'h100, 32'h80, 0, 32'h100);
    idle(32'h100);

    // Saturate to strongly taken; one not-taken still predicts taken
    for (int i = 0; i < 3; i++) drive(1, 1, 3'd0, 1, 0, 32'h100, 32'h80, 1, 32'h100);
    drive(1, 1, 3'd0, 0, 0, 32'h100, 32'h80, 1, 32'h100);
    idle(32'h100);

    // bne not taken at 0x1FC, wrong-path branch during the redirect is ignored
    drive(1, 1, 3'd1, 1, 0, 32'h1FC, 32'h40, 1, 32'h1FC);
    drive(1, 1, 3'd1, 0, 0, 32'h1FC, 32'h40, 0, 32'h1FC);
    idle(32'h1FC);

    // Reserved funct3 resolves not taken
    drive(1, 1, 3'd2, 1, 1, 32'h104, 32'h10, 0, 32'h104);
    drive(1, 1, 3'd3, 0, 0, 32'h104, 32'h10, 1, 32'h104);
    idle(32'h104);
    drive(1, 0, 3'd0, 1, 0, 32'h104, 32'h10, 0, 32'h104);
    reset_mid();

    // Twenty mispredicts saturate both narrow counters
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 3'd0, 1, 0, pcs[i % 5], 32'h800 + 32'(i), 0, pcs[i % 5]);
      idle(pcs[(i + 1) % 5]);
    end
    // Reset while the redirect is pending, then a normal first resolution
    drive(1, 1, 3'd0, 1, 0, 32'h100, 32'h80, 0, 32'h100);
    reset_mid();
    drive(1, 1, 3'd4, 0, 1, 32'h100, 32'h90, 0, 32'h100);
    idle(32'h100);

    // Randomized bursts with aliasing PCs and same-cycle lookup/update
    for (int b = 0; b < 25; b++) begin
      for (int i = 0; i < 14; i++) begin
        pc  = pcs[$urandom_range(0, 4)];
        fpc = ($urandom_range(0, 1) == 1) ? pc : pcs[$urandom_range(0, 4)];
        f3  = 3'($urandom_range(0, 7));
        z   = 1'($urandom); lt = 1'($urandom);
        pr  = ($urandom_range(0, 3) == 0) ? 1'($urandom) : (m_tbl[slot(pc)] >= 2);
        drive(($urandom_range(0, 7) != 0), ($urandom_range(0, 5) != 0), f3, z, lt,
              pc, $urandom, pr, fpc);
      end
      reset_mid();
    end

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain pending %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning PC/target width.
REQ-002 SHALL have parameter BHT_ENTRIES, default 64, meaning predictor table depth; a power of 2, at least 2.
REQ-003 SHALL have parameter CNT_W, default 32, meaning performance counter width.
REQ-004 SHALL have ports, one per line:
  clk  in  1  sole clock, rising edge.
  reset  in  1  asynchronous, active-high.
  f_pc  in  XLEN  fetch-stage PC for lookup.
  f_pred_taken  out  1  prediction for f_pc.
  ex_valid  in  1  EX stage holds a live instruction.
  ex_is_branch  in  1  EX instruction is a conditional branch.
  ex_funct3  in  3  branch type.
  ex_zero  in  1  ALU zero flag.
  ex_lt  in  1  ALU less-than result (signed or unsigned per funct3).
  ex_pc  in  XLEN  PC of EX branch.
  ex_target  in  XLEN  computed taken target.
  ex_pred_taken  in  1  prediction carried down with the branch.
  redirect  out  1  registered mispredict redirect.
  redirect_pc  out  XLEN  registered correct next PC.
  branch_cnt  out  CNT_W  resolved-branch count.
  mispred_cnt  out  CNT_W  mispredict count.

Function
REQ-005 SHALL hold BHT_ENTRIES 2-bit saturating counters; index = pc[IDX_W+1:2], IDX_W = log2(BHT_ENTRIES).
REQ-006 f_pred_taken SHALL be combinational: MSB of the counter at f_pc's index.
REQ-007 The actual outcome SHALL be: 000 -> ex_zero; 001 -> !ex_zero; 100, 110 -> ex_lt; 101, 111 -> !ex_lt; 010, 011 -> not taken.
REQ-008 A resolution SHALL occur when ex_valid && ex_is_branch && !redirect.
REQ-009 On resolution, the indexed counter SHALL increment if taken, else decrement, saturating at 3 and 0; the update SHALL be visible from the next cycle.
REQ-010 A same-cycle lookup and update of one index SHALL return the pre-update value.
REQ-011 A mispredict SHALL be a resolution where the outcome != ex_pred_taken.
REQ-012 On a mispredict, redirect SHALL be 1 in the following cycle only.
REQ-013 On a mispredict, redirect_pc SHALL be ex_target if the outcome is taken, else ex_pc + 4 (mod 2^XLEN).
REQ-014 redirect_pc SHALL hold its last value when redirect is 0.
REQ-015 While redirect is 1, the EX instruction is wrong-path: no table update, no count update, no new redirect.
REQ-016 branch_cnt SHALL increment on each resolution and saturate at all-ones.
REQ-017 mispred_cnt SHALL increment on each mispredict and saturate at all-ones.
REQ-018 Funct3 010/011 branches SHALL count and update as not taken.
REQ-019 Non-branch or invalid EX cycles SHALL change no state.

Reset
REQ-020 Reset SHALL immediately set all table counters to 01 (weakly not-taken).
REQ-021 Reset SHALL immediately set redirect = 0, redirect_pc = 0, branch_cnt = 0 and mispred_cnt = 0.
REQ-022 A reset during a pending redirect SHALL cancel it; the first resolution after release is handled normally.

Structure
REQ-023 A shared package SHALL hold the funct3 branch encodings and the counter state constants (SNT=00, WNT=01, WT=10, ST=11).
REQ-024 Outcome decode SHALL be a sub-module branch_cond_eval (funct3, zero, lt -> taken).
REQ-025 The table and counters SHALL stay in the top module.

Verification
REQ-026 After reset, f_pc = any -> f_pred_taken = 0; both counts = 0.
REQ-027 Beq at ex_pc=0x100, ex_zero=1, pred=0, target=0x80 -> next cycle redirect=1, redirect_pc=0x80, mispred_cnt=1; f_pc=0x100 then predicts 1.
REQ-028 Three taken beq at 0x100 (pred=1 after the first) -> counter saturates at 11; one not-taken -> still predicts taken.
REQ-029 Bne ex_zero=1 at ex_pc=0x1FC, pred=1 -> redirect_pc=0x200; a branch in EX next cycle (redirect=1) -> counts and table unchanged.
REQ-030 funct3=010, pred=0 -> no redirect; branch_cnt += 1.
REQ-031 CNT_W=4: 20 mispredicts -> both counts = 15; reset asserted while redirect pending -> redirect=0 immediately.
